pc_seq_unit: RTL and testbench

- Parametrised next-PC sequencer; successor to the fixed 32-bit increment/branch PC register.
- Holds the architectural PC and computes the next PC from sequential, branch, absolute-jump, register-jump and return sources.
- Adds stall support and a small return-address stack (RAS) for call/return.
- Sits at the head of the fetch path; its PC output drives instruction memory.

---
 rtl/pc_seq_unit_if.sv | 41 ++++
 rtl/pc_seq_unit.sv | 123 ++++++++++++
 tb/tb_pc_seq_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pc_seq_unit_if.sv
// Fetch-side handle for the next-PC sequencer: control requests in, PC and RAS status out.
// misalign exists only when PC_SEQ_ALIGN_CHECK_EN is defined.
interface pc_seq_unit_if #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16
);
  logic             stall;
  logic             br_take;
  logic [IMM_W-1:0] imm;
  logic             jmp;
  logic [WIDTH-1:0] jmp_target;
  logic             jr;
  logic [WIDTH-1:0] jr_addr;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_ovf;
  logic             ras_unf;
`ifdef PC_SEQ_ALIGN_CHECK_EN
  logic             misalign;
`endif

  modport master (
    output stall, br_take, imm, jmp, jmp_target, jr, jr_addr, call, ret,
    input  pc, pc_plus4, ras_empty, ras_full, ras_ovf, ras_unf
`ifdef PC_SEQ_ALIGN_CHECK_EN
    , input misalign
`endif
  );

  modport slave (
    input  stall, br_take, imm, jmp, jmp_target, jr, jr_addr, call, ret,
    output pc, pc_plus4, ras_empty, ras_full, ras_ovf, ras_unf
`ifdef PC_SEQ_ALIGN_CHECK_EN
    , output misalign
`endif
  );
endinterface

// File: rtl/pc_seq_unit.sv
// Next-PC sequencer with stall and a circular return-address stack.
// Optional PC_SEQ_ALIGN_CHECK_EN: registered misalign flag and word-aligned stored PC.
module pc_seq_unit #(
  parameter int          WIDTH     = 32,
  parameter int          IMM_W     = 16,
  parameter logic [31:0] RESET_PC  = 32'h00400020,
  parameter int          RAS_DEPTH = 4
) (
  input logic          clk,
  input logic          reset,
  pc_seq_unit_if.slave bus
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_mem_d [RAS_DEPTH];

  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] pc_sel;
  logic             ras_is_empty;
  logic             ras_is_full;

`ifdef PC_SEQ_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
`endif

  always_comb begin
    pc_plus4     = pc_q + WIDTH'(4);
    imm_ext      = {{(WIDTH-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
    br_target    = pc_plus4 + (imm_ext << 2);
    ras_is_empty = (count_q == '0);
    ras_is_full  = (count_q == CNT_W'(RAS_DEPTH));

    // ret beats every other redirect; an empty stack falls through to pc+4
    if (bus.ret)          pc_sel = ras_is_empty ? pc_plus4 : ras_mem_q[top_q];
    else if (bus.jr)      pc_sel = bus.jr_addr;
    else if (bus.jmp)     pc_sel = bus.jmp_target;
    else if (bus.br_take) pc_sel = br_target;
    else                  pc_sel = pc_plus4;
  end

  always_comb begin
    pc_d      = pc_q;
    top_d     = top_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    ras_mem_d = ras_mem_q;
`ifdef PC_SEQ_ALIGN_CHECK_EN
    misalign_d = 1'b0;
`endif
    if (!bus.stall) begin
`ifdef PC_SEQ_ALIGN_CHECK_EN
      pc_d       = {pc_sel[WIDTH-1:2], 2'b00};
      misalign_d = |pc_sel[1:0];
`else
      pc_d = pc_sel;
`endif
      if (bus.call && bus.ret) begin
        // pop-then-push in place: pointer stays, depth only grows from empty
        ras_mem_d[top_q] = pc_plus4;
        if (ras_is_empty) begin
          count_d = CNT_W'(1);
          unf_d   = 1'b1;
        end
      end else if (bus.call) begin
        ras_mem_d[top_q + PTR_W'(1)] = pc_plus4;
        top_d = top_q + PTR_W'(1);
        if (ras_is_full) ovf_d = 1'b1;
        else             count_d = count_q + CNT_W'(1);
      end else if (bus.ret) begin
        if (ras_is_empty) begin
          unf_d = 1'b1;
        end else begin
          top_d   = top_q - PTR_W'(1);
          count_d = count_q - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= WIDTH'(RESET_PC);
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem_q[i] <= '0;
`ifdef PC_SEQ_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      pc_q      <= pc_d;
      top_q     <= top_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      ras_mem_q <= ras_mem_d;
`ifdef PC_SEQ_ALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_plus4  = pc_plus4;
  assign bus.ras_empty = ras_is_empty;
  assign bus.ras_full  = ras_is_full;
  assign bus.ras_ovf   = ovf_q;
  assign bus.ras_unf   = unf_q;
`ifdef PC_SEQ_ALIGN_CHECK_EN
  assign bus.misalign  = misalign_q;
`endif
endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed bench for pc_seq_unit: reset, sequencing, branches, call/ret, RAS limits, stall, priority, wrap.
module tb_pc_seq_unit;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_seq_unit_if #(.WIDTH(32), .IMM_W(16)) sif ();

  pc_seq_unit #(
    .WIDTH(32), .IMM_W(16), .RESET_PC(32'h00400020), .RAS_DEPTH(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (sif)
  );

  task automatic clear_inputs();
    sif.stall = 0; sif.br_take = 0; sif.imm = '0; sif.jmp = 0; sif.jmp_target = '0;
    sif.jr = 0; sif.jr_addr = '0; sif.call = 0; sif.ret = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input logic [31:0] target);
    clear_inputs();
    sif.jmp = 1; sif.jmp_target = target;
    step();
    clear_inputs();
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    clear_inputs();
    reset = 1;
    step();
    reset = 0;
    checks++; if (sif.pc !== 32'h00400020) begin errors++; $display("FAIL reset_pc got %h exp %h", sif.pc, 32'h00400020); end
    checks++; if ({sif.ras_empty, sif.ras_full, sif.ras_ovf, sif.ras_unf} !== 4'b1000) begin errors++; $display("FAIL reset_flags got %b exp 1000", {sif.ras_empty, sif.ras_full, sif.ras_ovf, sif.ras_unf}); end
    exp_pc = 32'h00400020;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc = exp_pc + 32'd4;
      checks++; if (sif.pc !== exp_pc) begin errors++; $display("FAIL idle%0d pc got %h exp %h", i, sif.pc, exp_pc); end
    end
    checks++; if (sif.ras_empty !== 1'b1) begin errors++; $display("FAIL idle_empty got %b exp 1", sif.ras_empty); end
  endtask

  task automatic test_branch();
    go_to(32'h00400030);
    sif.br_take = 1; sif.imm = 16'hFFFE;
    step();
    checks++; if (sif.pc !== 32'h0040002C) begin errors++; $display("FAIL br_neg got %h exp %h", sif.pc, 32'h0040002C); end
    go_to(32'h00400030);
    sif.br_take = 1; sif.imm = 16'h0003;
    step();
    checks++; if (sif.pc !== 32'h00400040) begin errors++; $display("FAIL br_pos got %h exp %h", sif.pc, 32'h00400040); end
    clear_inputs();
  endtask

  task automatic test_call_ret();
    go_to(32'h00400100);
    sif.jmp = 1; sif.call = 1; sif.jmp_target = 32'h00401000;
    step();
    checks++; if (sif.pc !== 32'h00401000) begin errors++; $display("FAIL call_pc got %h exp %h", sif.pc, 32'h00401000); end
    checks++; if (sif.ras_empty !== 1'b0) begin errors++; $display("FAIL call_empty got %b exp 0", sif.ras_empty); end
    clear_inputs();
    sif.ret = 1;
    step();
    checks++; if (sif.pc !== 32'h00400104) begin errors++; $display("FAIL ret_pc got %h exp %h", sif.pc, 32'h00400104); end
    checks++; if (sif.ras_empty !== 1'b1) begin errors++; $display("FAIL ret_empty got %b exp 1", sif.ras_empty); end
    clear_inputs();
  endtask

  task automatic test_ras_limits();
    logic [31:0] exp_ret [4] = '{32'h504, 32'h404, 32'h304, 32'h204};
    go_to(32'h00000100);
    for (int i = 1; i <= 5; i++) begin
      sif.jmp = 1; sif.call = 1; sif.jmp_target = 32'((i + 1) * 32'h100);
      step();
      checks++; if (sif.pc !== 32'((i + 1) * 32'h100)) begin errors++; $display("FAIL push%0d pc got %h exp %h", i, sif.pc, 32'((i + 1) * 32'h100)); end
    end
    clear_inputs();
    checks++; if ({sif.ras_full, sif.ras_ovf, sif.ras_unf} !== 3'b110) begin errors++; $display("FAIL ovf_flags got %b exp 110", {sif.ras_full, sif.ras_ovf, sif.ras_unf}); end
    sif.ret = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (sif.pc !== exp_ret[i]) begin errors++; $display("FAIL pop%0d pc got %h exp %h", i, sif.pc, exp_ret[i]); end
    end
    checks++; if ({sif.ras_empty, sif.ras_full, sif.ras_unf} !== 3'b100) begin errors++; $display("FAIL drained got %b exp 100", {sif.ras_empty, sif.ras_full, sif.ras_unf}); end
    step();
    checks++; if (sif.pc !== 32'h208) begin errors++; $display("FAIL unf_pc got %h exp %h", sif.pc, 32'h208); end
    checks++; if ({sif.ras_empty, sif.ras_unf, sif.ras_ovf} !== 3'b111) begin errors++; $display("FAIL unf_flags got %b exp 111", {sif.ras_empty, sif.ras_unf, sif.ras_ovf}); end
    clear_inputs();
  endtask

  task automatic test_stall();
    sif.stall = 1; sif.br_take = 1; sif.call = 1; sif.imm = 16'h0004;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (sif.pc !== 32'h208 || sif.ras_empty !== 1'b1) begin errors++; $display("FAIL stall%0d got pc %h empty %b exp pc 00000208 empty 1", i, sif.pc, sif.ras_empty); end
    end
    sif.stall = 0;
    step();
    checks++; if (sif.pc !== 32'h21C) begin errors++; $display("FAIL release_pc got %h exp %h", sif.pc, 32'h21C); end
    checks++; if (sif.ras_empty !== 1'b0) begin errors++; $display("FAIL release_push got %b exp 0", sif.ras_empty); end
    clear_inputs();
  endtask

  task automatic test_call_and_ret();
    sif.call = 1; sif.ret = 1;
    step();
    checks++; if (sif.pc !== 32'h20C || sif.ras_empty !== 1'b0) begin errors++; $display("FAIL swap_top got pc %h empty %b exp pc 0000020c empty 0", sif.pc, sif.ras_empty); end
    clear_inputs(); sif.ret = 1;
    step();
    checks++; if (sif.pc !== 32'h220 || sif.ras_empty !== 1'b1) begin errors++; $display("FAIL swap_pop got pc %h empty %b exp pc 00000220 empty 1", sif.pc, sif.ras_empty); end
    sif.call = 1;
    step();
    checks++; if (sif.pc !== 32'h224 || sif.ras_empty !== 1'b0) begin errors++; $display("FAIL swap_empty got pc %h empty %b exp pc 00000224 empty 0", sif.pc, sif.ras_empty); end
    clear_inputs(); sif.ret = 1;
    step();
    checks++; if (sif.pc !== 32'h224 || sif.ras_empty !== 1'b1) begin errors++; $display("FAIL swap_entry got pc %h empty %b exp pc 00000224 empty 1", sif.pc, sif.ras_empty); end
    clear_inputs();
  endtask

  task automatic test_priority();
    sif.jmp = 1; sif.call = 1; sif.jmp_target = 32'h1000;
    step();
    clear_inputs();
    sif.ret = 1; sif.jr = 1; sif.jmp = 1; sif.br_take = 1;
    sif.jr_addr = 32'h2000; sif.jmp_target = 32'h3000; sif.imm = 16'h0001;
    step();
    checks++; if (sif.pc !== 32'h228) begin errors++; $display("FAIL prio_ret got %h exp %h", sif.pc, 32'h228); end
    sif.ret = 0;
    step();
    checks++; if (sif.pc !== 32'h2000) begin errors++; $display("FAIL prio_jr got %h exp %h", sif.pc, 32'h2000); end
    sif.jr = 0;
    step();
    checks++; if (sif.pc !== 32'h3000) begin errors++; $display("FAIL prio_jmp got %h exp %h", sif.pc, 32'h3000); end
    sif.jmp = 0;
    step();
    checks++; if (sif.pc !== 32'h3008) begin errors++; $display("FAIL prio_br got %h exp %h", sif.pc, 32'h3008); end
    clear_inputs();
  endtask

  task automatic test_wrap();
    go_to(32'hFFFFFFFC);
    checks++; if (sif.pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4 got %h exp 00000000", sif.pc_plus4); end
    step();
    checks++; if (sif.pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp 00000000", sif.pc); end
  endtask

  task automatic test_reset_during_ret();
    sif.jmp = 1; sif.call = 1; sif.jmp_target = 32'h500;
    step();
    clear_inputs();
    sif.ret = 1; reset = 1;
    step();
    reset = 0;
    clear_inputs();
    checks++; if (sif.pc !== 32'h00400020) begin errors++; $display("FAIL rst_ret_pc got %h exp %h", sif.pc, 32'h00400020); end
    checks++; if ({sif.ras_empty, sif.ras_full, sif.ras_ovf, sif.ras_unf} !== 4'b1000) begin errors++; $display("FAIL rst_ret_flags got %b exp 1000", {sif.ras_empty, sif.ras_full, sif.ras_ovf, sif.ras_unf}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_branch();
    test_call_ret();
    test_ras_limits();
    test_stall();
    test_call_and_ret();
    test_priority();
    test_wrap();
    test_reset_during_ret();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
